machine_trap_control: RTL
=========================

MACHINE_TRAP_CONTROL -- requirements
Module: machine_trap_control

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameters, one per line (name, default, meaning):
 NUM_PLAT_IRQ, 4, platform interrupt lines, 1..16
 RESET_FLUSH_CYCLES, 2, cycles held in RESET after rst_n_in deasserts, >=1
REQ-003 SHALL have ports, one per line (name, direction, width, meaning):
 clk_in  in  1  clock
 rst_n_in  in  1  async active-low reset
 illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in  in  1 each  exception flags
 opcode_6_to_2_in  in  5  decoded opcode bits
 funct3_in  in  3  decoded field
 funct7_in  in  7  decoded field
 rs1_adder_in, rs2_adder_in, rd_adder_in  in  5 each  register addresses
 mie_in  in  1  mstatus.MIE
 meie_in, mtie_in, msie_in  in  1 each  mie enables
 meip_in, mtip_in, msip_in  in  1 each  mip pending
 eirq_in, tirq_in, sirq_in  in  1 each  raw interrupt lines
 plat_irq_in  in  NUM_PLAT_IRQ  platform interrupt lines
 plat_ie_in  in  NUM_PLAT_IRQ  platform interrupt enables
 pc_src_out  out  2  00 BOOT, 01 NEXT, 10 TRAP, 11 EPC
 flush_out  out  1  pipeline flush
 trap_taken_out  out  1  high during TRAP_TAKEN
 set_epc_out, set_cause_out  out  1 each  CSR write strobes
 mie_clear_out, mie_set_out  out  1 each  MIE update strobes
 instret_inc_out  out  1  instruction retire increment
 i_or_e_out  out  1  1 interrupt, 0 exception
 cause_out  out  5  mcause code

Function
REQ-004 SHALL implement states RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
REQ-005 RESET SHALL last RESET_FLUSH_CYCLES cycles (down-counter), then go to OPERATING.
REQ-006 SHALL decode, with system = opcode 11100, funct3=0, rs1=0, rd=0: ecall = rs2=0, funct7=0; ebreak = rs2=1, funct7=0; mret = rs2=2, funct7=0011000.
REQ-007 SHALL define pending interrupts as: eip = meie&(eirq|meip); sip = msie&(sirq|msip); tip = mtie&(tirq|mtip); pip[i] = plat_ie[i]&plat_irq[i].
REQ-008 SHALL define trap in OPERATING as any exception | ecall | ebreak | (mie_in & any pending interrupt); a trap SHALL move to TRAP_TAKEN next cycle.
REQ-009 mret without a trap in OPERATING SHALL move to TRAP_RETURN next cycle; a trap SHALL take priority over a simultaneous mret.
REQ-010 TRAP_TAKEN and TRAP_RETURN SHALL last exactly one cycle, then return to OPERATING; inputs are ignored in these states.
REQ-011 Outputs SHALL decode from state only:
 RESET: pc_src 00, flush 1, all others 0
 OPERATING: pc_src 01, instret_inc 1, all others 0
 TRAP_TAKEN: pc_src 10, flush, trap_taken, set_epc, set_cause and mie_clear 1, instret_inc 0
 TRAP_RETURN: pc_src 11, flush 1, mie_set 1, others 0
REQ-012 On the OPERATING->TRAP_TAKEN edge, cause_out and i_or_e_out SHALL register the highest-priority source, first listed wins:
 eip (1,11); sip (1,3); tip (1,7); pip lowest index i (1,16+i); illegal (0,2); misaligned instr (0,0); ecall (0,11); ebreak (0,3); misaligned store (0,6); misaligned load (0,4).
 Both values SHALL be held until the next trap.
REQ-013 Interrupt sources SHALL enter the REQ-012 priority only when mie_in=1.

Reset
REQ-014 rst_n_in low SHALL immediately force state RESET, reload the counter, and clear cause_out and i_or_e_out to 0.
REQ-015 During reset, outputs SHALL follow RESET decode: pc_src 00, flush 1, all others 0.
REQ-016 Reset asserted in any state, including TRAP_TAKEN, SHALL abort that state.

Structure
REQ-017 Package machine_ctrl_pkg SHALL hold the state enum, pc_src encodings and cause codes.
REQ-018 Sub-module trap_cause_encoder SHALL hold the combinational priority of REQ-012, parametrised by NUM_PLAT_IRQ.

Verification
REQ-019 Reset, RESET_FLUSH_CYCLES=2: release rst_n_in -> pc_src 00 with flush 1 for 2 cycles, then pc_src 01 with instret_inc 1.
REQ-020 ecall in OPERATING -> 1 cycle of pc_src 10 with set_epc/set_cause/mie_clear 1; cause_out 11, i_or_e 0; then pc_src 01.
REQ-021 mie_in=1, meie=1, eirq=1, with illegal_instr in the same cycle -> cause 11, i_or_e 1; with mie_in=0 -> cause 2, i_or_e 0.
REQ-022 plat_irq=4'b1010, plat_ie=4'b1111, mie_in=1 -> cause 17.
REQ-023 mret together with misaligned_load -> TRAP_TAKEN, cause 4; mret alone -> pc_src 11, mie_set 1 for 1 cycle.
REQ-024 rst_n_in low during TRAP_TAKEN -> same-cycle pc_src 00, cause_out 0.

Source files
------------

// File: rtl/machine_ctrl_pkg.sv
// Purpose: shared types and constants for the machine-mode trap controller.
//   state_e     : controller FSM states
//   PC_*        : pc_src_out encodings
//   CAUSE_*     : mcause codes for interrupts and exceptions
//   exc_src_t   : bundle of synchronous exception sources fed to the cause encoder
package machine_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET       = 2'b00,
    ST_OPERATING   = 2'b01,
    ST_TRAP_TAKEN  = 2'b10,
    ST_TRAP_RETURN = 2'b11
  } state_e;

  localparam int unsigned PC_SRC_W = 2;
  localparam logic [PC_SRC_W-1:0] PC_BOOT = 2'b00;
  localparam logic [PC_SRC_W-1:0] PC_NEXT = 2'b01;
  localparam logic [PC_SRC_W-1:0] PC_TRAP = 2'b10;
  localparam logic [PC_SRC_W-1:0] PC_EPC  = 2'b11;

  localparam int unsigned CAUSE_W = 5;
  localparam logic [CAUSE_W-1:0] CAUSE_M_EXT_IRQ        = 5'd11;
  localparam logic [CAUSE_W-1:0] CAUSE_M_SW_IRQ         = 5'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_M_TIMER_IRQ      = 5'd7;
  localparam logic [CAUSE_W-1:0] CAUSE_PLAT_BASE        = 5'd16;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL          = 5'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGNED_INSTR = 5'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL            = 5'd11;
  localparam logic [CAUSE_W-1:0] CAUSE_EBREAK           = 5'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGNED_STORE = 5'd6;
  localparam logic [CAUSE_W-1:0] CAUSE_MISALIGNED_LOAD  = 5'd4;

  localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;
  localparam logic [6:0] FUNCT7_MRET   = 7'b0011000;

  typedef struct packed {
    logic illegal;
    logic misaligned_instr;
    logic ecall;
    logic ebreak;
    logic misaligned_store;
    logic misaligned_load;
  } exc_src_t;

endpackage

// File: rtl/trap_cause_encoder.sv
// Purpose: combinational trap detection and mcause priority encoding.
// Ports:
//   mie_in            : global machine interrupt enable (gates all interrupts)
//   eip_in/sip_in/tip_in : enabled-and-pending external/software/timer interrupts
//   pip_in            : enabled-and-pending platform interrupts
//   exc_in            : synchronous exception sources
//   trap_c            : a trap is requested this cycle
//   cause_c, i_or_e_c : highest-priority cause code and interrupt(1)/exception(0) flag
module trap_cause_encoder
  import machine_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PLAT_IRQ = 4
) (
  input  logic                    mie_in,
  input  logic                    eip_in,
  input  logic                    sip_in,
  input  logic                    tip_in,
  input  logic [NUM_PLAT_IRQ-1:0] pip_in,
  input  exc_src_t                exc_in,
  output logic                    trap_c,
  output logic [CAUSE_W-1:0]      cause_c,
  output logic                    i_or_e_c
);

  logic       w_pip_any;
  logic [3:0] w_pip_idx;

  // Lowest-numbered pending platform line wins; scan downward so the last hit is the lowest.
  always_comb begin
    w_pip_idx = 4'd0;
    for (int i = int'(NUM_PLAT_IRQ) - 1; i >= 0; i--) begin
      if (pip_in[i]) w_pip_idx = 4'(i);
    end
  end

  assign w_pip_any = |pip_in;

  // Interrupts only compete when mie_in is set; exceptions always do.
  always_comb begin
    trap_c   = (|exc_in) | (mie_in & (eip_in | sip_in | tip_in | w_pip_any));
    cause_c  = '0;
    i_or_e_c = 1'b0;
    if (mie_in && eip_in) begin
      cause_c  = CAUSE_M_EXT_IRQ;
      i_or_e_c = 1'b1;
    end else if (mie_in && sip_in) begin
      cause_c  = CAUSE_M_SW_IRQ;
      i_or_e_c = 1'b1;
    end else if (mie_in && tip_in) begin
      cause_c  = CAUSE_M_TIMER_IRQ;
      i_or_e_c = 1'b1;
    end else if (mie_in && w_pip_any) begin
      cause_c  = CAUSE_W'(CAUSE_PLAT_BASE + CAUSE_W'(w_pip_idx));
      i_or_e_c = 1'b1;
    end else if (exc_in.illegal) begin
      cause_c = CAUSE_ILLEGAL;
    end else if (exc_in.misaligned_instr) begin
      cause_c = CAUSE_MISALIGNED_INSTR;
    end else if (exc_in.ecall) begin
      cause_c = CAUSE_ECALL;
    end else if (exc_in.ebreak) begin
      cause_c = CAUSE_EBREAK;
    end else if (exc_in.misaligned_store) begin
      cause_c = CAUSE_MISALIGNED_STORE;
    end else if (exc_in.misaligned_load) begin
      cause_c = CAUSE_MISALIGNED_LOAD;
    end
  end

endmodule

// File: rtl/machine_trap_control.sv
// Purpose: machine-mode trap controller FSM (RESET / OPERATING / TRAP_TAKEN / TRAP_RETURN).
// Ports:
//   clk_in, rst_n_in                 : clock, async active-low reset
//   exception flags, decoded fields  : trap sources and ecall/ebreak/mret decode inputs
//   mie_in, m*ie_in, m*ip_in, *irq_in: interrupt enables / pending / raw lines
//   plat_irq_in, plat_ie_in          : platform interrupt lines and enables
//   pc_src_out .. instret_inc_out    : control strobes decoded from the state register
//   i_or_e_out, cause_out            : registered trap cause, held until the next trap
module machine_trap_control
  import machine_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PLAT_IRQ       = 4,
  parameter int unsigned RESET_FLUSH_CYCLES = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    illegal_instr_in,
  input  logic                    misaligned_instr_in,
  input  logic                    misaligned_load_in,
  input  logic                    misaligned_store_in,
  input  logic [4:0]              opcode_6_to_2_in,
  input  logic [2:0]              funct3_in,
  input  logic [6:0]              funct7_in,
  input  logic [4:0]              rs1_adder_in,
  input  logic [4:0]              rs2_adder_in,
  input  logic [4:0]              rd_adder_in,
  input  logic                    mie_in,
  input  logic                    meie_in,
  input  logic                    mtie_in,
  input  logic                    msie_in,
  input  logic                    meip_in,
  input  logic                    mtip_in,
  input  logic                    msip_in,
  input  logic                    eirq_in,
  input  logic                    tirq_in,
  input  logic                    sirq_in,
  input  logic [NUM_PLAT_IRQ-1:0] plat_irq_in,
  input  logic [NUM_PLAT_IRQ-1:0] plat_ie_in,
  output logic [PC_SRC_W-1:0]     pc_src_out,
  output logic                    flush_out,
  output logic                    trap_taken_out,
  output logic                    set_epc_out,
  output logic                    set_cause_out,
  output logic                    mie_clear_out,
  output logic                    mie_set_out,
  output logic                    instret_inc_out,
  output logic                    i_or_e_out,
  output logic [CAUSE_W-1:0]      cause_out
);

  localparam int unsigned CNT_W = (RESET_FLUSH_CYCLES > 1) ? $clog2(RESET_FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESET_FLUSH_CYCLES - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CAUSE_W-1:0] r_cause;
  logic               r_i_or_e;

  logic               w_system;
  logic               w_ecall;
  logic               w_ebreak;
  logic               w_mret;
  logic               w_eip;
  logic               w_sip;
  logic               w_tip;
  logic [NUM_PLAT_IRQ-1:0] w_pip;
  exc_src_t           w_exc;
  logic               w_trap;
  logic [CAUSE_W-1:0] w_cause;
  logic               w_i_or_e;

  // SYSTEM-opcode decode for ecall / ebreak / mret.
  assign w_system = (opcode_6_to_2_in == OPCODE_SYSTEM) && (funct3_in == 3'd0) &&
                    (rs1_adder_in == 5'd0) && (rd_adder_in == 5'd0);
  assign w_ecall  = w_system && (rs2_adder_in == 5'd0) && (funct7_in == 7'd0);
  assign w_ebreak = w_system && (rs2_adder_in == 5'd1) && (funct7_in == 7'd0);
  assign w_mret   = w_system && (rs2_adder_in == 5'd2) && (funct7_in == FUNCT7_MRET);

  // Enabled-and-pending interrupt terms.
  assign w_eip = meie_in & (eirq_in | meip_in);
  assign w_sip = msie_in & (sirq_in | msip_in);
  assign w_tip = mtie_in & (tirq_in | mtip_in);
  assign w_pip = plat_ie_in & plat_irq_in;

  assign w_exc = '{illegal:          illegal_instr_in,
                   misaligned_instr: misaligned_instr_in,
                   ecall:            w_ecall,
                   ebreak:           w_ebreak,
                   misaligned_store: misaligned_store_in,
                   misaligned_load:  misaligned_load_in};

  trap_cause_encoder #(
    .NUM_PLAT_IRQ(NUM_PLAT_IRQ)
  ) u_cause_enc (
    .mie_in   (mie_in),
    .eip_in   (w_eip),
    .sip_in   (w_sip),
    .tip_in   (w_tip),
    .pip_in   (w_pip),
    .exc_in   (w_exc),
    .trap_c   (w_trap),
    .cause_c  (w_cause),
    .i_or_e_c (w_i_or_e)
  );

  // State and reset-flush counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_RESET;
      r_cnt   <= CNT_LOAD;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Cause is captured only on the OPERATING->TRAP_TAKEN transition and held otherwise.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_cause  <= '0;
      r_i_or_e <= 1'b0;
    end else if ((r_state == ST_OPERATING) && w_trap) begin
      r_cause  <= w_cause;
      r_i_or_e <= w_i_or_e;
    end
  end

  // Next-state and state-decoded control strobes.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    pc_src_out      = PC_BOOT;
    flush_out       = 1'b0;
    trap_taken_out  = 1'b0;
    set_epc_out     = 1'b0;
    set_cause_out   = 1'b0;
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    instret_inc_out = 1'b0;
    case (r_state)
      ST_RESET: begin
        flush_out = 1'b1;
        if (r_cnt == '0) w_state_nxt = ST_OPERATING;
        else             w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
      ST_OPERATING: begin
        pc_src_out      = PC_NEXT;
        instret_inc_out = 1'b1;
        // A trap beats a simultaneous mret.
        if (w_trap)      w_state_nxt = ST_TRAP_TAKEN;
        else if (w_mret) w_state_nxt = ST_TRAP_RETURN;
      end
      ST_TRAP_TAKEN: begin
        pc_src_out     = PC_TRAP;
        flush_out      = 1'b1;
        trap_taken_out = 1'b1;
        set_epc_out    = 1'b1;
        set_cause_out  = 1'b1;
        mie_clear_out  = 1'b1;
        w_state_nxt    = ST_OPERATING;
      end
      ST_TRAP_RETURN: begin
        pc_src_out  = PC_EPC;
        flush_out   = 1'b1;
        mie_set_out = 1'b1;
        w_state_nxt = ST_OPERATING;
      end
      default: w_state_nxt = ST_RESET;
    endcase
  end

  assign cause_out  = r_cause;
  assign i_or_e_out = r_i_or_e;

endmodule
